// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote oversampling, parity/framing/break detection,
// and a small receive FIFO with a valid/ready handshake towards the host.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = $clog2(DIV + 1);
    localparam int unsigned SAMP_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DATA_BITS + 2;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SAMP_W-1:0] S_LO      = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] S_MID     = SAMP_W'(OVERSAMPLE / 2);
    localparam logic [SAMP_W-1:0] S_HI      = SAMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMP_W-1:0] S_LAST    = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } state_e;

    // Line synchroniser and tick divider
    logic             rxd_meta_q;
    logic             rxd_sync_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;

    // Frame FSM
    state_e                 state_q;
    logic [SAMP_W-1:0]      samp_q;
    logic [1:0]             smp_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   stop_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_bit_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   break_det_q;

    logic                   vote;
    logic                   exp_par;
    logic                   last_stop;
    logic                   is_break;
    logic                   push;
    logic [ENTRY_W-1:0]     push_entry;

    // FIFO
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overrun_q;
    logic                   full;
    logic                   pop;
    logic                   do_push;
    logic [ENTRY_W-1:0]     head;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            div_cnt_q  <= '0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            div_cnt_q  <= tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        // Third vote sample is the live synchronised value at index OVERSAMPLE/2+1
        vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_sync_q) | (smp_q[1] & rxd_sync_q);
        exp_par   = (PARITY == 1) ? ~^shift_q : ^shift_q;
        last_stop = (stop_idx_q == STOP_LAST);
        is_break  = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !vote && !stop_idx_q;
        push      = tick && (state_q == StStop) && (samp_q == S_HI) && last_stop && !is_break;
        push_entry = {ferr_q | ~vote, perr_q, shift_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            samp_q      <= '0;
            smp_q       <= '0;
            bit_q       <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            break_det_q <= 1'b0;
        end else begin
            break_det_q <= 1'b0;
            if (tick) begin
                if (state_q != StIdle && state_q != StBrkWait) begin
                    samp_q <= (samp_q == S_LAST) ? '0 : samp_q + SAMP_W'(1);
                    if (samp_q == S_LO)  smp_q[0] <= rxd_sync_q;
                    if (samp_q == S_MID) smp_q[1] <= rxd_sync_q;
                end
                case (state_q)
                    StIdle: begin
                        if (!rxd_sync_q) begin
                            state_q    <= StStart;
                            samp_q     <= '0;
                            bit_q      <= '0;
                            stop_idx_q <= 1'b0;
                            perr_q     <= 1'b0;
                            ferr_q     <= 1'b0;
                        end
                    end
                    StStart: begin
                        if (samp_q == S_HI && vote) begin
                            state_q <= StIdle;
                        end else if (samp_q == S_LAST) begin
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (samp_q == S_HI) begin
                            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        end
                        if (samp_q == S_LAST) begin
                            if (bit_q == BIT_LAST) begin
                                state_q <= (PARITY != 0) ? StParity : StStop;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                    StParity: begin
                        if (samp_q == S_HI) begin
                            par_bit_q <= vote;
                            perr_q    <= (vote != exp_par);
                        end
                        if (samp_q == S_LAST) begin
                            state_q <= StStop;
                        end
                    end
                    StStop: begin
                        // Complete half a bit early so the next start edge is never missed
                        if (samp_q == S_HI) begin
                            if (is_break) begin
                                state_q     <= StBrkWait;
                                break_det_q <= 1'b1;
                            end else if (last_stop) begin
                                state_q <= StIdle;
                            end else begin
                                ferr_q <= ferr_q | ~vote;
                            end
                        end else if (samp_q == S_LAST) begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                    StBrkWait: begin
                        if (rxd_sync_q) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        full    = (count_q == FULL);
        pop     = (count_q != '0) && rx_ready;
        do_push = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && full && !pop;
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        rx_valid   = (count_q != '0);
        rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
        parity_err = rx_valid & head[DATA_BITS];
        frame_err  = rx_valid & head[DATA_BITS+1];
        fifo_count = count_q;
        break_det  = break_det_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default 8N1 instance plus an even-parity, 2-stop, fast-baud instance,
// each checked against a frame-level model and an expected-entry queue.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int unsigned BIT0  = 432;
    localparam int unsigned CLK_P = 115200 * 8 * 4;
    localparam int unsigned BIT1  = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd0 = 1'b1, rxd1 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1;

    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       parity_err0, parity_err1, frame_err0, frame_err1;
    logic       break_det0, break_det1, overrun0, overrun1;
    logic [2:0] fifo_count0, fifo_count1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise0    = 0;
    int vcyc0    = 0;
    int npop0    = 0;
    int obs_brk[2] = '{0, 0};
    int obs_ov[2]  = '{0, 0};
    int exp_brk[2] = '{0, 0};
    int exp_ov[2]  = '{0, 0};
    logic vprev0 = 1'b0;
    bit   rnd_done = 1'b0;
    logic [9:0] exp0[$];
    logic [9:0] exp1[$];

    always #5 clk = ~clk;

    uart_rx_param dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd0),
        .rx_data    (rx_data0),
        .rx_valid   (rx_valid0),
        .rx_ready   (rdy0),
        .parity_err (parity_err0),
        .frame_err  (frame_err0),
        .break_det  (break_det0),
        .overrun    (overrun0),
        .fifo_count (fifo_count0)
    );

    uart_rx_param #(
        .CLK_FREQ   (CLK_P),
        .OVERSAMPLE (8),
        .PARITY     (2),
        .STOP_BITS  (2)
    ) dut_p (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd1),
        .rx_data    (rx_data1),
        .rx_valid   (rx_valid1),
        .rx_ready   (rdy1),
        .parity_err (parity_err1),
        .frame_err  (frame_err1),
        .break_det  (break_det1),
        .overrun    (overrun1),
        .fifo_count (fifo_count1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic b);
        if (ch == 0) rxd0 = b;
        else         rxd1 = b;
    endtask

    // Expected FIFO effect of one frame, from the line-level frame contents alone
    function automatic void model_push(input int ch, input logic [7:0] data, input bit has_par,
                                       input bit pbit, input bit bad_par, input bit bad_stop);
        logic [9:0] e;
        if (reset) return;
        e = {bad_stop, has_par && bad_par, data};
        if (data == 8'd0 && (!has_par || !pbit) && bad_stop) begin
            exp_brk[ch]++;
        end else if (ch == 0) begin
            if (exp0.size() >= DEPTH) exp_ov[0]++;
            else exp0.push_back(e);
        end else begin
            if (exp1.size() >= DEPTH) exp_ov[1]++;
            else exp1.push_back(e);
        end
    endfunction

    task automatic send_frame(input int ch, input logic [7:0] data, input bit bad_par,
                              input bit bad_stop);
        int bt;
        int nstop;
        bit has_par;
        bit pbit;
        bt      = (ch == 0) ? BIT0 : BIT1;
        nstop   = (ch == 0) ? 1 : 2;
        has_par = (ch != 0);
        pbit    = (^data) ^ bad_par;
        drive(ch, 1'b0);
        cycles(bt);
        for (int i = 0; i < 8; i++) begin
            drive(ch, data[i]);
            cycles(bt);
        end
        if (has_par) begin
            drive(ch, pbit);
            cycles(bt);
        end
        model_push(ch, data, has_par, pbit, bad_par, bad_stop);
        for (int s = 0; s < nstop; s++) begin
            drive(ch, !(s == 0 && bad_stop));
            cycles(bt);
        end
        drive(ch, 1'b1);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (break_det0) obs_brk[0]++;
            if (break_det1) obs_brk[1]++;
            if (overrun0)   obs_ov[0]++;
            if (overrun1)   obs_ov[1]++;
            if (rx_valid0 && !vprev0) rise0 = cyc;
            if (rx_valid0) vcyc0++;
            if (rx_valid0 && rdy0) begin
                npop0++;
                if (exp0.size() == 0)
                    check_val("pop0_unexpected", {22'd0, frame_err0, parity_err0, rx_data0}, 32'hffff_ffff);
                else
                    check_val("pop0", {22'd0, frame_err0, parity_err0, rx_data0}, {22'd0, exp0.pop_front()});
            end
            if (rx_valid1 && rdy1) begin
                if (exp1.size() == 0)
                    check_val("pop1_unexpected", {22'd0, frame_err1, parity_err1, rx_data1}, 32'hffff_ffff);
                else
                    check_val("pop1", {22'd0, frame_err1, parity_err1, rx_data1}, {22'd0, exp1.pop_front()});
            end
        end
        vprev0 = rx_valid0;
    end

    initial begin
        int start;
        int lat;
        int pops_before;
        logic [7:0] d;

        reset = 1'b1;
        cycles(5);
        check_val("reset_outputs0", {rx_valid0, fifo_count0, rx_data0, parity_err0, frame_err0,
                                     break_det0, overrun0}, 32'd0);
        check_val("reset_outputs1", {rx_valid1, fifo_count1, rx_data1, parity_err1, frame_err1,
                                     break_det1, overrun1}, 32'd0);
        reset = 1'b0;
        cycles(BIT0);

        // 8N1 0xA5: one-cycle valid within the latency bound
        vcyc0 = 0;
        start = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b0);
        cycles(3 * BIT0);
        lat = rise0 - start;
        check_val("t1_latency_in_range", {31'd0, (lat >= 4000 && lat <= 4330)}, 32'd1);
        check_val("t1_valid_cycles", vcyc0, 32'd1);
        check_val("t1_drained", exp0.size(), 32'd0);

        // Even parity: 0x03 with a wrong then a right parity bit
        send_frame(1, 8'h03, 1'b1, 1'b0);
        cycles(3 * BIT1);
        send_frame(1, 8'h03, 1'b0, 1'b0);
        cycles(3 * BIT1);
        check_val("t2_drained", exp1.size(), 32'd0);

        // Stop bit 0, then a clean frame
        send_frame(0, 8'h55, 1'b0, 1'b1);
        cycles(2 * BIT0);
        send_frame(0, 8'h12, 1'b0, 1'b0);
        cycles(2 * BIT0);
        check_val("t3_no_break", obs_brk[0], exp_brk[0]);
        check_val("t3_drained", exp0.size(), 32'd0);

        // False start: 81 clocks low
        pops_before = npop0;
        rxd0 = 1'b0;
        cycles(81);
        rxd0 = 1'b1;
        cycles(2 * BIT0);
        check_val("t4_no_write", npop0 - pops_before, 32'd0);
        check_val("t4_count", fifo_count0, 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        cycles(2 * BIT0);
        check_val("t4_drained", exp0.size(), 32'd0);

        // Overrun: consumer stalled, five frames into a four-entry FIFO
        rdy0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(0, 8'(k), 1'b0, 1'b0);
            cycles(BIT0);
            if (k == 4) begin
                check_val("t5_count_at4", fifo_count0, 32'd4);
                check_val("t5_no_overrun_yet", obs_ov[0], 32'd0);
            end
        end
        check_val("t5_count_at5", fifo_count0, 32'd4);
        check_val("t5_overrun", obs_ov[0], exp_ov[0]);
        check_val("t5_valid_held", rx_valid0, 32'd1);
        rdy0 = 1'b1;
        cycles(10);
        check_val("t5_drained", exp0.size(), 32'd0);
        check_val("t5_count_empty", fifo_count0, 32'd0);

        // Break: line low for two frame times
        rxd0 = 1'b0;
        cycles(2 * 10 * BIT0);
        rxd0 = 1'b1;
        exp_brk[0]++;
        cycles(2 * BIT0);
        check_val("t6_break_pulses", obs_brk[0], exp_brk[0]);
        check_val("t6_count", fifo_count0, 32'd0);

        // Reset in the middle of 0x77 with one entry already stored
        rdy0 = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0);
        cycles(BIT0);
        check_val("t6_prestored_valid", rx_valid0, 32'd1);
        fork
            send_frame(0, 8'h77, 1'b0, 1'b0);
            begin
                cycles(5 * BIT0);
                reset = 1'b1;
                exp0.delete();
                cycles(1);
                check_val("t6_reset_valid", rx_valid0, 32'd0);
            end
        join
        reset = 1'b0;
        cycles(2 * BIT0);
        check_val("t6_reset_count", fifo_count0, 32'd0);
        check_val("t6_reset_no_valid", rx_valid0, 32'd0);
        rdy0 = 1'b1;

        // Randomised traffic on the parity instance with a random-ready consumer
        send_frame(1, 8'h00, 1'b0, 1'b1);
        cycles(3 * BIT1);
        fork
            begin
                for (int f = 0; f < 16; f++) begin
                    d = 8'($urandom);
                    if ($urandom_range(0, 5) == 0) d = 8'h00;
                    send_frame(1, d, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
                    cycles(3 * BIT1 + $urandom_range(0, BIT1));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    cycles(1);
                    rdy1 = 1'($urandom_range(0, 1));
                end
            end
        join
        rdy1 = 1'b1;
        cycles(4 * BIT1);
        check_val("rnd_drained", exp1.size(), 32'd0);
        check_val("rnd_breaks", obs_brk[1], exp_brk[1]);
        check_val("rnd_overruns", obs_ov[1], exp_ov[1]);
        check_val("final_overruns0", obs_ov[0], exp_ov[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
